// File: rtl/uart_matrix_loader_pkg.sv
// Shared types and width helpers for the UART matrix loader: FSM states, error codes,
// and helpers that size the matrix-select, address and per-element byte counters.
package uart_matrix_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_FRAMING  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

    function automatic int msel_w_calc(input int num_mat);
        return (num_mat > 1) ? $clog2(num_mat) : 1;
    endfunction

    function automatic int addr_w_calc(input int elems);
        return (elems > 1) ? $clog2(elems) : 1;
    endfunction

    function automatic int bytes_per_elem(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/uart_matrix_loader_if.sv
// Byte-stream input from the UART receiver and element-write output toward the matrix memories.
// master = UART/memory side, slave = the loader.
interface uart_matrix_loader_if #(
    parameter int DATA_W = 8,
    parameter int MSEL_W = 1,
    parameter int ADDR_W = 2
);
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              rx_ferr;
    logic              mem_we;
    logic [MSEL_W-1:0] mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output rx_valid, rx_byte, rx_ferr,
        input  mem_we, mem_sel, mem_addr, mem_wdata
    );

    modport slave (
        input  rx_valid, rx_byte, rx_ferr,
        output mem_we, mem_sel, mem_addr, mem_wdata
    );
endinterface

// File: rtl/uart_matrix_loader_byte_assembler.sv
// Collects DATA_W/8 bytes (first byte = least significant) into one element and
// presents it with a one-cycle elem_valid the cycle after the completing byte.
module byte_assembler
    import uart_matrix_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              elem_valid,
    output logic [DATA_W-1:0] elem_data
);
    localparam int BPE   = bytes_per_elem(DATA_W);
    localparam int CNT_W = (BPE > 1) ? $clog2(BPE) : 1;

    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] elem_data_reg;
    logic [CNT_W-1:0]  byte_cnt_reg;
    logic              elem_valid_reg;
    logic [DATA_W-1:0] assembled;
    logic              last_byte;

    // New byte enters at the top so the first byte ends up in the low lane.
    assign assembled = (shift_reg >> 8) | (DATA_W'(byte_in) << (DATA_W - 8));
    assign last_byte = (byte_cnt_reg == CNT_W'(BPE - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg      <= '0;
            elem_data_reg  <= '0;
            byte_cnt_reg   <= '0;
            elem_valid_reg <= 1'b0;
        end else begin
            elem_valid_reg <= 1'b0;
            if (clear) begin
                shift_reg    <= '0;
                byte_cnt_reg <= '0;
            end else if (byte_valid) begin
                shift_reg <= assembled;
                if (last_byte) begin
                    byte_cnt_reg   <= '0;
                    elem_valid_reg <= 1'b1;
                    elem_data_reg  <= assembled;
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign elem_valid = elem_valid_reg;
    assign elem_data  = elem_data_reg;
endmodule

// File: rtl/uart_matrix_loader.sv
// Loads NUM_MAT matrices of ROWS x COLS elements from a UART byte stream, one memory write per element.
// Define UART_MATRIX_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before completion.
module uart_matrix_loader
    import uart_matrix_pkg::*;
#(
    parameter int NUM_MAT     = 2,
    parameter int ROWS        = 2,
    parameter int COLS        = 2,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    uart_matrix_loader_if.slave  bus,
    output logic                 busy,
    output logic                 complete,
    output logic                 err,
    output logic [1:0]           err_code
);
    localparam int MSEL_W      = msel_w_calc(NUM_MAT);
    localparam int ELEMS       = ROWS * COLS;
    localparam int ADDR_W      = addr_w_calc(ELEMS);
    localparam int TOTAL_BYTES = NUM_MAT * ELEMS * bytes_per_elem(DATA_W);
    localparam int BCNT_W      = $clog2(TOTAL_BYTES + 1);

    state_t            state_reg, state_next;
    logic [1:0]        err_code_reg, err_code_next;
    logic [MSEL_W-1:0] sel_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [BCNT_W-1:0] bcnt_reg;
    logic              started_reg;
    logic              active, all_in, accept, tmo_hit, elem_valid;
    logic [DATA_W-1:0] elem_data;

    assign active = (state_reg == LOAD) || (state_reg == CHECK);
    // Once every data byte is in, further bytes are refused even while the final write is still pending.
    assign all_in = (bcnt_reg == BCNT_W'(TOTAL_BYTES));
    assign accept = bus.rx_valid && !bus.rx_ferr && !clear && (state_reg == LOAD) && !all_in;

    byte_assembler #(.DATA_W(DATA_W)) u_assembler (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .byte_valid (accept),
        .byte_in    (bus.rx_byte),
        .elem_valid (elem_valid),
        .elem_data  (elem_data)
    );

    // Element position advances after each write, so mem_sel/mem_addr hold during the write cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_reg     <= '0;
            addr_reg    <= '0;
            bcnt_reg    <= '0;
            started_reg <= 1'b0;
        end else if (clear) begin
            sel_reg     <= '0;
            addr_reg    <= '0;
            bcnt_reg    <= '0;
            started_reg <= 1'b0;
        end else begin
            if (accept) begin
                bcnt_reg    <= bcnt_reg + 1'b1;
                started_reg <= 1'b1;
            end
            if (elem_valid) begin
                if (addr_reg == ADDR_W'(ELEMS - 1)) begin
                    addr_reg <= '0;
                    sel_reg  <= (sel_reg == MSEL_W'(NUM_MAT - 1)) ? '0 : sel_reg + 1'b1;
                end else begin
                    addr_reg <= addr_reg + 1'b1;
                end
            end
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_tmo
            localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
            logic [TMO_W-1:0] tmo_cnt_reg;
            logic             running;

            assign running = started_reg && active;
            assign tmo_hit = running && !bus.rx_valid && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    tmo_cnt_reg <= '0;
                end else if (!running || bus.rx_valid || clear) begin
                    tmo_cnt_reg <= '0;
                end else begin
                    tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                end
            end
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

`ifdef UART_MATRIX_LOADER_CHECKSUM_EN
    logic [7:0] csum_reg;
    logic       last_byte;

    assign last_byte = (bcnt_reg == BCNT_W'(TOTAL_BYTES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_reg <= '0;
        end else if (clear) begin
            csum_reg <= '0;
        end else if (accept) begin
            csum_reg <= csum_reg ^ bus.rx_byte;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= LOAD;
            err_code_reg <= ERR_NONE;
        end else begin
            state_reg    <= state_next;
            err_code_reg <= err_code_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        err_code_next = err_code_reg;
        if (clear) begin
            state_next    = LOAD;
            err_code_next = ERR_NONE;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (bus.rx_valid && bus.rx_ferr) begin
                        state_next    = ERR;
                        err_code_next = ERR_FRAMING;
                    end else if (tmo_hit) begin
                        state_next    = ERR;
                        err_code_next = ERR_TIMEOUT;
`ifdef UART_MATRIX_LOADER_CHECKSUM_EN
                    end else if (accept && last_byte) begin
                        state_next = CHECK;
`else
                    end else if (elem_valid && all_in) begin
                        state_next = DONE;
`endif
                    end
                end
`ifdef UART_MATRIX_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (bus.rx_valid && bus.rx_ferr) begin
                        state_next    = ERR;
                        err_code_next = ERR_FRAMING;
                    end else if (bus.rx_valid) begin
                        if (bus.rx_byte == csum_reg) begin
                            state_next = DONE;
                        end else begin
                            state_next    = ERR;
                            err_code_next = ERR_CHECKSUM;
                        end
                    end else if (tmo_hit) begin
                        state_next    = ERR;
                        err_code_next = ERR_TIMEOUT;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign busy          = started_reg && active;
    assign complete      = (state_reg == DONE);
    assign err           = (state_reg == ERR);
    assign err_code      = err_code_reg;
    assign bus.mem_we    = elem_valid;
    assign bus.mem_sel   = sel_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = elem_data;
endmodule

// File: tb/tb_uart_matrix_loader.sv
// Scoreboard bench: stimulus pushes expected writes, per-instance monitors pop and compare on mem_we.
// Covers an 8-bit loader (timeout 50) and a 16-bit loader side by side.
module tb_uart_matrix_loader;
    import uart_matrix_pkg::*;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [3:0]  sel;
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk, rst, clear;
    logic busy8, complete8, err8, busy16, complete16, err16;
    logic [1:0] code8, code16;
    int checks = 0;
    int errors = 0;
    wr_t exp8_q[$];
    wr_t exp16_q[$];
    byte_q_t q;

    uart_matrix_loader_if #(.DATA_W(8),  .MSEL_W(1), .ADDR_W(2)) if8 ();
    uart_matrix_loader_if #(.DATA_W(16), .MSEL_W(1), .ADDR_W(2)) if16 ();

    uart_matrix_loader #(.NUM_MAT(2), .ROWS(2), .COLS(2), .DATA_W(8), .TIMEOUT_CYC(50)) dut (
        .clk(clk), .rst(rst), .clear(clear), .bus(if8),
        .busy(busy8), .complete(complete8), .err(err8), .err_code(code8)
    );

    uart_matrix_loader #(.NUM_MAT(2), .ROWS(2), .COLS(2), .DATA_W(16), .TIMEOUT_CYC(50)) dut16 (
        .clk(clk), .rst(rst), .clear(clear), .bus(if16),
        .busy(busy16), .complete(complete16), .err(err16), .err_code(code16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input bit wide, input int sel, input int addr, input logic [15:0] data);
        wr_t e;
        e.sel  = 4'(sel);
        e.addr = 4'(addr);
        e.data = data;
        if (wide) exp16_q.push_back(e);
        else      exp8_q.push_back(e);
    endtask

    function automatic logic [7:0] qxor(input byte_q_t b);
        logic [7:0] x = 8'h00;
        foreach (b[i]) x ^= b[i];
        return x;
    endfunction

    // Back-to-back bytes, one per cycle; optional framing error on the last one.
    task automatic burst(input bit wide, input byte_q_t b, input bit ferr_last);
        for (int i = 0; i < b.size(); i++) begin
            if (wide) begin
                if16.rx_valid = 1'b1; if16.rx_byte = b[i]; if16.rx_ferr = ferr_last && (i == b.size() - 1);
            end else begin
                if8.rx_valid = 1'b1; if8.rx_byte = b[i]; if8.rx_ferr = ferr_last && (i == b.size() - 1);
            end
            tick(1);
        end
        if8.rx_valid = 1'b0; if8.rx_ferr = 1'b0;
        if16.rx_valid = 1'b0; if16.rx_ferr = 1'b0;
    endtask

    task automatic one_byte(input logic [7:0] b, input bit ferr);
        byte_q_t s;
        s.push_back(b);
        burst(1'b0, s, ferr);
        tick(1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic full_load8(input logic [7:0] base, input string name);
        byte_q_t s;
        for (int i = 0; i < 8; i++) begin
            s.push_back(base + 8'(i));
            exp_push(1'b0, i / 4, i % 4, {8'h00, base + 8'(i)});
        end
`ifdef UART_MATRIX_LOADER_CHECKSUM_EN
        s.push_back(qxor(s));
`endif
        burst(1'b0, s, 1'b0);
        tick(2);
        chk({name, "_complete"}, complete8, 1);
        chk({name, "_err"}, err8, 0);
    endtask

    initial begin : mon8
        wr_t e;
        forever begin
            @(negedge clk);
            if (if8.mem_we === 1'b1) begin
                $display("w8  sel=%0d addr=%0d data=%h", if8.mem_sel, if8.mem_addr, if8.mem_wdata);
                if (exp8_q.size() == 0) begin
                    chk("w8_unexpected", {8'h00, 3'b0, if8.mem_sel, 2'b0, if8.mem_addr, 8'h00, if8.mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp8_q.pop_front();
                    chk("w8", {8'h00, 3'b0, if8.mem_sel, 2'b0, if8.mem_addr, 8'h00, if8.mem_wdata}, {8'h00, e});
                end
            end
        end
    end

    initial begin : mon16
        wr_t e;
        forever begin
            @(negedge clk);
            if (if16.mem_we === 1'b1) begin
                $display("w16 sel=%0d addr=%0d data=%h", if16.mem_sel, if16.mem_addr, if16.mem_wdata);
                if (exp16_q.size() == 0) begin
                    chk("w16_unexpected", {8'h00, 3'b0, if16.mem_sel, 2'b0, if16.mem_addr, if16.mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp16_q.pop_front();
                    chk("w16", {8'h00, 3'b0, if16.mem_sel, 2'b0, if16.mem_addr, if16.mem_wdata}, {8'h00, e});
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b0; clear = 1'b0;
        if8.rx_valid = 1'b0;  if8.rx_byte = 8'h00;  if8.rx_ferr = 1'b0;
        if16.rx_valid = 1'b0; if16.rx_byte = 8'h00; if16.rx_ferr = 1'b0;
        tick(3);
        chk("rst_outputs", {if8.mem_we, busy8, complete8, err8, code8, if8.mem_sel, if8.mem_addr}, 0);
        chk("rst_wdata", if8.mem_wdata, 0);
        rst = 1'b1;
        tick(2);

        // Default stream 01..08, exact completion timing relative to the last write
        q = {};
        for (int i = 0; i < 8; i++) begin
            q.push_back(8'(i + 1));
            exp_push(1'b0, i / 4, i % 4, 16'(i + 1));
        end
`ifdef UART_MATRIX_LOADER_CHECKSUM_EN
        q.push_back(qxor(q));
        burst(1'b0, q, 1'b0);
`else
        burst(1'b0, q, 1'b0);
        chk("t1_last_write", if8.mem_we, 1);
        chk("t1_complete_early", complete8, 0);
        tick(1);
`endif
        chk("t1_complete", complete8, 1);
        chk("t1_busy_done", busy8, 0);
        one_byte(8'h55, 1'b0);
        tick(2);
        chk("t1_done_sticky", complete8, 1);
        pulse_clear();
        chk("t1_clear", {complete8, busy8, err8, code8}, 0);

`ifdef UART_MATRIX_LOADER_CHECKSUM_EN
        q = {};
        for (int i = 0; i < 8; i++) begin
            q.push_back(8'(i + 1));
            exp_push(1'b0, i / 4, i % 4, 16'(i + 1));
        end
        q.push_back(8'h00);
        burst(1'b0, q, 1'b0);
        tick(2);
        chk("cs_err_code", code8, ERR_CHECKSUM);
        chk("cs_complete", complete8, 0);
        pulse_clear();
`endif

        // Framing error on third byte
        exp_push(1'b0, 0, 0, 16'h0011);
        exp_push(1'b0, 0, 1, 16'h0022);
        one_byte(8'h11, 1'b0);
        chk("fe_busy", busy8, 1);
        one_byte(8'h22, 1'b0);
        one_byte(8'h33, 1'b1);
        tick(2);
        chk("fe_err", {err8, code8, busy8}, {1'b1, ERR_FRAMING, 1'b0});
        one_byte(8'h44, 1'b0);
        tick(2);
        chk("fe_sticky", {err8, code8}, {1'b1, ERR_FRAMING});
        pulse_clear();
        chk("fe_clear", {err8, code8}, 0);
        full_load8(8'hA0, "fe_reload");
        pulse_clear();

        // Timeout: idle before first byte is harmless, silence after bytes is not
        tick(80);
        chk("tmo_idle", err8, 0);
        q = {};
        q.push_back(8'h5A); q.push_back(8'hA5);
        exp_push(1'b0, 0, 0, 16'h005A);
        exp_push(1'b0, 0, 1, 16'h00A5);
        burst(1'b0, q, 1'b0);
        tick(40);
        chk("tmo_before", {err8, busy8}, {1'b0, 1'b1});
        tick(15);
        chk("tmo_after", {err8, code8, busy8}, {1'b1, ERR_TIMEOUT, 1'b0});
        pulse_clear();

        // Reset during the fifth byte: write of byte 4 is cut off asynchronously
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(8'(i + 1));
        for (int i = 0; i < 3; i++) exp_push(1'b0, 0, i, 16'(i + 1));
        burst(1'b0, q, 1'b0);
        chk("rr_we_before", if8.mem_we, 1);
        if8.rx_valid = 1'b1; if8.rx_byte = 8'h05;
        #2 rst = 1'b0;
        #1;
        chk("rr_async", {if8.mem_we, busy8, complete8, err8, code8, if8.mem_sel, if8.mem_addr}, 0);
        if8.rx_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        tick(1);
        full_load8(8'h11, "rr_reload");

        // 16-bit elements, trailing odd byte produces no write
        q = {};
        q.push_back(8'h34); q.push_back(8'h12); q.push_back(8'h78); q.push_back(8'h56); q.push_back(8'h9A);
        exp_push(1'b1, 0, 0, 16'h1234);
        exp_push(1'b1, 0, 1, 16'h5678);
        burst(1'b1, q, 1'b0);
        tick(5);
        chk("w16_state", {busy16, complete16, err16}, 3'b100);

        tick(2);
        chk("pending8", exp8_q.size(), 0);
        chk("pending16", exp16_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
